memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Single-port memory arbiter for the rv32i core. It shares the one read/write port of `memory` between two requesters: instruction fetch (read-only) and the execute-stage load/store path (read or write). It sits between `fetch`/`execute` and `memory`. It serialises accesses with round-robin priority and returns responses through a grant/valid handshake.

## Interface

Parameters:
- `ADDRESS_WIDTH`, 32: width of all address buses.
- `DATA_WIDTH`, 32: width of all data buses.

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_request`  in  1  fetch wants an instruction read.
- `fetch_address`  in  ADDRESS_WIDTH  instruction address.
- `fetch_grant`  out  1  fetch transaction accepted (ISSUE cycle).
- `fetch_valid`  out  1  one-cycle pulse: `fetch_value` carries the response.
- `fetch_value`  out  DATA_WIDTH  instruction word.
- `data_request`  in  1  execute wants a load or store.
- `data_write`  in  1  1 = store, 0 = load; qualifies `data_request`.
- `data_address`  in  ADDRESS_WIDTH  load/store address.
- `data_write_value`  in  DATA_WIDTH  store data.
- `data_grant`  out  1  data transaction accepted (ISSUE cycle).
- `data_valid`  out  1  one-cycle pulse: load data ready, or store done.
- `data_read_value`  out  DATA_WIDTH  load result.
- `memory_read_enable`  out  1  to `memory.read_enable`.
- `memory_read_address`  out  ADDRESS_WIDTH  to `memory.read_address`.
- `memory_read_value`  in  DATA_WIDTH  from `memory.read_value`; valid one cycle after the read enable is sampled.
- `memory_write_enable`  out  1  to `memory.write_enable`.
- `memory_write_address`  out  ADDRESS_WIDTH  to `memory.write_address`.
- `memory_write_value`  out  DATA_WIDTH  to `memory.write_value`.

## Operation

- FSM states:
  - IDLE: no transaction.
  - ISSUE: memory command driven.
  - RESPOND: response presented.
- Arbitration happens only on edges that leave IDLE or RESPOND:
  - Neither request: go to (or stay in) IDLE.
  - One request: that port wins.
  - Both requests: the port not granted last wins. The `last_grant` register resets to "data", so fetch wins the first contention after reset.
- On a winning edge:
  - Go to ISSUE.
  - Register the winner ID, the address, write flag and write value into the memory-side output registers.
  - Update `last_grant`.
- ISSUE (one cycle):
  - Winner's grant = 1.
  - Read: `memory_read_enable` = 1 at the registered address.
  - Write: `memory_write_enable` = 1 with the registered address and value.
  - Next state is always RESPOND.
- RESPOND (one cycle):
  - Winner's valid = 1.
  - For a read, the winner's value output is driven from `memory_read_value`.
  - For a store, `data_valid` pulses and `data_read_value` is unchanged.
  - Arbitration for the next transaction happens on the edge ending this cycle.
- Response values: at the edge ending RESPOND, the read value is captured into a per-port hold register. `fetch_value`/`data_read_value` stay stable until that port's next valid.
- Requester contract:
  - Hold request, address and data stable until its grant.
  - Inputs may change freely after the grant (they are latched).
  - A request still high on the edge ending RESPOND is a new transaction.
- Fetch ignores `data_write`, so fetch never writes.
- Memory enables are never both 1 in the same cycle.

## Timing

- Reset (asynchronous, takes effect immediately):
  - State = IDLE, `last_grant` = data.
  - All enables, grants and valids = 0.
  - All address, data and value outputs and hold registers = 0.
- Latency: request sampled at edge N → grant and memory enable during cycle N+1 → valid during N+2.
- Throughput: one transaction per 2 cycles when requests are continuous; no idle bubble between back-to-back transactions.
- Contention under continuous requests alternates F, D, F, D…; neither port waits more than one transaction.
- Reset mid-transaction:
  - The in-flight response is dropped and no valid is produced.
  - A write already driven in ISSUE may have completed in memory.
- Request deasserted before grant: withdrawn, no transaction.

## Test plan

- Single fetch: after reset, `fetch_request`=1 at address 0x00000010 with memory word 0x00500093 → `fetch_grant` and `memory_read_enable` at N+1 with read address 0x10; `fetch_valid`, `fetch_value`=0x00500093 at N+2; `data_*` outputs stay 0.
- Store then load: data write of 0xDEADBEEF to 0x100 → `memory_write_enable` at N+1, `data_valid` at N+2, `memory_read_enable`=0 throughout. A following load from 0x100 → `data_read_value`=0xDEADBEEF two cycles after its sample edge.
- Contention: both requests held high for 8 cycles starting right after reset → grants in order fetch, data, fetch, data on cycles N+1, N+3, N+5, N+7; never both grants or both enables in one cycle.
- Value hold: fetch returns 0x11111111, then data load returns 0x22222222 → `fetch_value` remains 0x11111111 through the data transaction.
- Input latching: `data_address` changed from 0x200 to 0x300 in the grant cycle → `memory_read_address` stays 0x200 during ISSUE.
- Reset mid-op: assert `reset` during ISSUE of a fetch → all outputs 0 immediately, no `fetch_valid`. After release, a new fetch completes with normal latency.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one memory port between instruction fetch and load/store.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_grant,
  output logic                     fetch_valid,
  output logic [DATA_WIDTH-1:0]    fetch_value,
  input  logic                     data_request,
  input  logic                     data_write,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0]    data_write_value,
  output logic                     data_grant,
  output logic                     data_valid,
  output logic [DATA_WIDTH-1:0]    data_read_value,
  output logic                     memory_read_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_read_address,
  input  logic [DATA_WIDTH-1:0]    memory_read_value,
  output logic                     memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_write_address,
  output logic [DATA_WIDTH-1:0]    memory_write_value
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, win_q, win_d, wr_q, wr_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wval_q, wval_d, fhold_q, fhold_d, dhold_q, dhold_d;
  logic go, pick_data, rsp_read;
  // Port IDs: 0 = fetch, 1 = data. Data wins only if fetch is idle or fetch had the last grant.
  always_comb begin
    pick_data = data_request && (!fetch_request || !last_q);
    go = state_q != ISSUE && (fetch_request || data_request);
    state_d = state_q == ISSUE ? RESPOND : go ? ISSUE : IDLE;
    win_d = go ? pick_data : win_q;
    last_d = go ? pick_data : last_q;
    wr_d = go ? pick_data && data_write : wr_q;
    addr_d = go ? (pick_data ? data_address : fetch_address) : addr_q;
    wval_d = go && pick_data ? data_write_value : wval_q;
    rsp_read = state_q == RESPOND && !wr_q;
    fhold_d = rsp_read && !win_q ? memory_read_value : fhold_q;
    dhold_d = rsp_read && win_q ? memory_read_value : dhold_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      win_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wval_q <= '0;
      fhold_q <= '0;
      dhold_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      win_q <= win_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wval_q <= wval_d;
      fhold_q <= fhold_d;
      dhold_q <= dhold_d;
    end
  end
  assign fetch_grant = state_q == ISSUE && !win_q;
  assign data_grant = state_q == ISSUE && win_q;
  assign fetch_valid = state_q == RESPOND && !win_q;
  assign data_valid = state_q == RESPOND && win_q;
  assign fetch_value = fhold_d;
  assign data_read_value = dhold_d;
  assign memory_read_enable = state_q == ISSUE && !wr_q;
  assign memory_write_enable = state_q == ISSUE && wr_q;
  assign memory_read_address = addr_q;
  assign memory_write_address = addr_q;
  assign memory_write_value = wval_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of the fetch/data memory arbiter against a small synchronous memory.
module tb_memory_arbiter;
  logic clock = 0, reset = 1;
  logic fetch_request = 0, fetch_grant, fetch_valid;
  logic [31:0] fetch_address = 0, fetch_value;
  logic data_request = 0, data_write = 0, data_grant, data_valid;
  logic [31:0] data_address = 0, data_write_value = 0, data_read_value;
  logic memory_read_enable, memory_write_enable;
  logic [31:0] memory_read_address, memory_read_value, memory_write_address, memory_write_value;
  logic [31:0] mem [0:255];
  int total = 0, bad = 0;

  memory_arbiter dut (
    .clock(clock), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_grant(fetch_grant), .fetch_valid(fetch_valid), .fetch_value(fetch_value),
    .data_request(data_request), .data_write(data_write), .data_address(data_address),
    .data_write_value(data_write_value), .data_grant(data_grant), .data_valid(data_valid),
    .data_read_value(data_read_value),
    .memory_read_enable(memory_read_enable), .memory_read_address(memory_read_address),
    .memory_read_value(memory_read_value), .memory_write_enable(memory_write_enable),
    .memory_write_address(memory_write_address), .memory_write_value(memory_write_value)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (memory_write_enable) mem[memory_write_address[9:2]] <= memory_write_value;
    if (memory_read_enable) memory_read_value <= mem[memory_read_address[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h00500093;
    mem[8] = 32'h11111111;
    mem[16] = 32'h22222222;
    mem[128] = 32'hA5A5A5A5;
    mem[192] = 32'h5A5A5A5A;
    tick();
    tick();
    chk("rst_grants", {30'd0, fetch_grant, data_grant}, 32'd0);
    chk("rst_valids", {30'd0, fetch_valid, data_valid}, 32'd0);
    chk("rst_enables", {30'd0, memory_read_enable, memory_write_enable}, 32'd0);
    chk("rst_fvalue", fetch_value, 32'd0);
    chk("rst_dvalue", data_read_value, 32'd0);
    chk("rst_raddr", memory_read_address, 32'd0);
    chk("rst_wval", memory_write_value, 32'd0);
    @(negedge clock);
    reset = 0;
    fetch_request = 1;
    fetch_address = 32'h10;
    tick();
    fetch_request = 0;
    chk("f1_grant", {31'd0, fetch_grant}, 32'd1);
    chk("f1_re", {31'd0, memory_read_enable}, 32'd1);
    chk("f1_raddr", memory_read_address, 32'h10);
    chk("f1_dgrant", {31'd0, data_grant}, 32'd0);
    tick();
    chk("f1_valid", {31'd0, fetch_valid}, 32'd1);
    chk("f1_value", fetch_value, 32'h00500093);
    chk("f1_dvalid", {31'd0, data_valid}, 32'd0);
    chk("f1_dvalue", data_read_value, 32'd0);
    tick();
    chk("f1_valid_off", {31'd0, fetch_valid}, 32'd0);
    chk("f1_hold", fetch_value, 32'h00500093);
    data_request = 1;
    data_write = 1;
    data_address = 32'h100;
    data_write_value = 32'hDEADBEEF;
    tick();
    data_request = 0;
    data_write = 0;
    data_write_value = 32'h0;
    chk("st_grant", {31'd0, data_grant}, 32'd1);
    chk("st_we", {31'd0, memory_write_enable}, 32'd1);
    chk("st_re", {31'd0, memory_read_enable}, 32'd0);
    chk("st_waddr", memory_write_address, 32'h100);
    chk("st_wval", memory_write_value, 32'hDEADBEEF);
    tick();
    chk("st_valid", {31'd0, data_valid}, 32'd1);
    chk("st_re2", {31'd0, memory_read_enable}, 32'd0);
    chk("st_dvalue", data_read_value, 32'd0);
    data_request = 1;
    data_address = 32'h100;
    tick();
    data_request = 0;
    chk("ld_re", {31'd0, memory_read_enable}, 32'd1);
    chk("ld_we", {31'd0, memory_write_enable}, 32'd0);
    chk("ld_raddr", memory_read_address, 32'h100);
    tick();
    chk("ld_valid", {31'd0, data_valid}, 32'd1);
    chk("ld_value", data_read_value, 32'hDEADBEEF);
    tick();
    chk("ld_hold", data_read_value, 32'hDEADBEEF);
    fetch_request = 1;
    fetch_address = 32'h20;
    tick();
    fetch_request = 0;
    tick();
    chk("vh_fvalue", fetch_value, 32'h11111111);
    data_request = 1;
    data_address = 32'h40;
    tick();
    data_request = 0;
    chk("vh_fhold_issue", fetch_value, 32'h11111111);
    tick();
    chk("vh_dvalue", data_read_value, 32'h22222222);
    chk("vh_fhold_resp", fetch_value, 32'h11111111);
    chk("vh_fvalid", {31'd0, fetch_valid}, 32'd0);
    tick();
    data_request = 1;
    data_address = 32'h200;
    tick();
    data_address = 32'h300;
    data_request = 0;
    #1;
    chk("lat_raddr", memory_read_address, 32'h200);
    tick();
    chk("lat_value", data_read_value, 32'hA5A5A5A5);
    tick();
    reset = 1;
    #1;
    @(negedge clock);
    reset = 0;
    fetch_request = 1;
    fetch_address = 32'h10;
    data_request = 1;
    data_address = 32'h40;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ct_fgrant%0d", i), {31'd0, fetch_grant}, {31'd0, i % 4 == 0});
      chk($sformatf("ct_dgrant%0d", i), {31'd0, data_grant}, {31'd0, i % 4 == 2});
      chk($sformatf("ct_both_en%0d", i), {31'd0, memory_read_enable & memory_write_enable}, 32'd0);
    end
    fetch_request = 0;
    data_request = 0;
    tick();
    chk("ct_last_dvalue", data_read_value, 32'h22222222);
    tick();
    fetch_request = 1;
    fetch_address = 32'h10;
    tick();
    fetch_request = 0;
    chk("ro_grant", {31'd0, fetch_grant}, 32'd1);
    reset = 1;
    #1;
    chk("ro_grant_off", {31'd0, fetch_grant}, 32'd0);
    chk("ro_re_off", {31'd0, memory_read_enable}, 32'd0);
    chk("ro_raddr", memory_read_address, 32'd0);
    chk("ro_fvalue", fetch_value, 32'd0);
    tick();
    chk("ro_no_valid", {31'd0, fetch_valid}, 32'd0);
    @(negedge clock);
    reset = 0;
    tick();
    chk("ro_no_valid2", {31'd0, fetch_valid}, 32'd0);
    fetch_request = 1;
    tick();
    fetch_request = 0;
    chk("ro2_grant", {31'd0, fetch_grant}, 32'd1);
    tick();
    chk("ro2_valid", {31'd0, fetch_valid}, 32'd1);
    chk("ro2_value", fetch_value, 32'h00500093);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
